// File: rtl/common.sv
// -----------------------------------------------------------------------------
// common: shared types for the five-stage RISC-V core.
//   forward_type   - execute-stage operand source select
//   hazard_state_t - hazard controller FSM states
//   forward_sel()  - operand select from the EX/MEM hazard matches
// -----------------------------------------------------------------------------
package common;

    typedef enum logic [1:0] {
        FORWARD_NONE     = 2'd0,
        FORWARD_FROM_MEM = 2'd1,
        FORWARD_FROM_WB  = 2'd2
    } forward_type;

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        LOAD_STALL = 2'd1,
        FLUSH      = 2'd2
    } hazard_state_t;

    // An EX match wins over a MEM match. A load in EX cannot be forwarded yet;
    // that case is covered by the load-use bubble.
    function automatic forward_type forward_sel(input logic ex_match,
                                                input logic mem_match,
                                                input logic ex_ld);
        if (ex_match) begin
            return ex_ld ? FORWARD_NONE : FORWARD_FROM_MEM;
        end else if (mem_match) begin
            return FORWARD_FROM_WB;
        end
        return FORWARD_NONE;
    endfunction

endpackage

// File: rtl/hazard_match.sv
// -----------------------------------------------------------------------------
// hazard_match: compares one source register against one pipeline stage.
//   i_rs         - source register index
//   i_rs_used    - the instruction reads i_rs
//   i_stage_rd   - destination register of the stage
//   i_stage_wr   - the stage writes i_stage_rd
//   o_match      - hazard on this source/stage pair (never on x0)
// -----------------------------------------------------------------------------
module hazard_match #(
    parameter int unsigned REG_ID_W = 5
) (
    input  logic [REG_ID_W-1:0] i_rs,
    input  logic                i_rs_used,
    input  logic [REG_ID_W-1:0] i_stage_rd,
    input  logic                i_stage_wr,
    output logic                o_match
);

    assign o_match = i_rs_used && i_stage_wr && (i_stage_rd == i_rs) && (i_rs != '0);

endmodule

// File: rtl/hazard_control_unit.sv
// -----------------------------------------------------------------------------
// hazard_control_unit: pipeline hazard controller for the five-stage core.
// Tracks the destination registers in EX and MEM, drives the registered
// forward selects, inserts the load-use bubble and flushes on taken branches.
//   i_clk, i_reset_n            - clock, async active-low reset
//   i_id_*                      - ID-stage instruction description
//   i_ex_pc_src                 - taken branch/jump resolved in EX
//   i_freeze                    - global pipeline hold
//   o_forward_rs1/o_forward_rs2 - execute-stage operand selects (registered)
//   o_stall_if/o_stall_id       - hold PC+IF/ID, hold ID
//   o_ex_bubble/o_flush_id      - NOP into ID/EX, clear IF/ID
//   o_stall_count/o_flush_count - saturating event counters
// -----------------------------------------------------------------------------
module hazard_control_unit
    import common::*;
#(
    parameter int unsigned REG_ID_W = 5,
    parameter int unsigned CNT_W    = 16
) (
    input  logic                i_clk,
    input  logic                i_reset_n,
    input  logic                i_id_valid,
    input  logic [REG_ID_W-1:0] i_id_rs1,
    input  logic [REG_ID_W-1:0] i_id_rs2,
    input  logic                i_id_uses_rs1,
    input  logic                i_id_uses_rs2,
    input  logic [REG_ID_W-1:0] i_id_rd,
    input  logic                i_id_reg_write,
    input  logic                i_id_mem_read,
    input  logic                i_ex_pc_src,
    input  logic                i_freeze,
    output forward_type         o_forward_rs1,
    output forward_type         o_forward_rs2,
    output logic                o_stall_if,
    output logic                o_stall_id,
    output logic                o_ex_bubble,
    output logic                o_flush_id,
    output logic [CNT_W-1:0]    o_stall_count,
    output logic [CNT_W-1:0]    o_flush_count
);

    hazard_state_t       r_state, w_state_next;
    logic [REG_ID_W-1:0] r_ex_rd, r_mem_rd;
    logic                r_ex_wr, r_ex_ld, r_mem_wr;
    forward_type         r_fwd_rs1, r_fwd_rs2;
    forward_type         w_fwd_rs1, w_fwd_rs2;
    logic [CNT_W-1:0]    r_stall_cnt, r_flush_cnt;

    logic w_rs1_ex, w_rs1_mem, w_rs2_ex, w_rs2_mem;
    logic w_load_use;
    logic w_stall, w_bubble, w_flush;
    logic w_stall_evt, w_flush_evt;

    hazard_match #(.REG_ID_W(REG_ID_W)) u_match_rs1_ex (
        .i_rs       (i_id_rs1),
        .i_rs_used  (i_id_uses_rs1),
        .i_stage_rd (r_ex_rd),
        .i_stage_wr (r_ex_wr),
        .o_match    (w_rs1_ex)
    );

    hazard_match #(.REG_ID_W(REG_ID_W)) u_match_rs1_mem (
        .i_rs       (i_id_rs1),
        .i_rs_used  (i_id_uses_rs1),
        .i_stage_rd (r_mem_rd),
        .i_stage_wr (r_mem_wr),
        .o_match    (w_rs1_mem)
    );

    hazard_match #(.REG_ID_W(REG_ID_W)) u_match_rs2_ex (
        .i_rs       (i_id_rs2),
        .i_rs_used  (i_id_uses_rs2),
        .i_stage_rd (r_ex_rd),
        .i_stage_wr (r_ex_wr),
        .o_match    (w_rs2_ex)
    );

    hazard_match #(.REG_ID_W(REG_ID_W)) u_match_rs2_mem (
        .i_rs       (i_id_rs2),
        .i_rs_used  (i_id_uses_rs2),
        .i_stage_rd (r_mem_rd),
        .i_stage_wr (r_mem_wr),
        .o_match    (w_rs2_mem)
    );

    assign w_load_use = i_id_valid && (w_rs1_ex || w_rs2_ex) && r_ex_ld;

    always_comb begin
        w_fwd_rs1 = FORWARD_NONE;
        w_fwd_rs2 = FORWARD_NONE;
        if (i_id_valid) begin
            w_fwd_rs1 = forward_sel(w_rs1_ex, w_rs1_mem, r_ex_ld);
            w_fwd_rs2 = forward_sel(w_rs2_ex, w_rs2_mem, r_ex_ld);
        end
    end

    // Next state and control outputs. Freeze overrides everything and the
    // branch wins over load-use, since the ID instruction is being squashed.
    always_comb begin
        w_state_next = r_state;
        w_stall      = 1'b0;
        w_bubble     = 1'b0;
        w_flush      = 1'b0;
        w_stall_evt  = 1'b0;
        w_flush_evt  = 1'b0;
        if (i_freeze) begin
            w_stall = 1'b1;
        end else begin
            case (r_state)
                RUN: begin
                    if (i_ex_pc_src) begin
                        w_state_next = FLUSH;
                        w_flush_evt  = 1'b1;
                    end else if (w_load_use) begin
                        w_state_next = LOAD_STALL;
                        w_stall      = 1'b1;
                        w_bubble     = 1'b1;
                        w_stall_evt  = 1'b1;
                    end
                end
                LOAD_STALL: w_state_next = RUN;
                FLUSH: begin
                    w_flush      = 1'b1;
                    w_bubble     = 1'b1;
                    w_state_next = RUN;
                end
                default: w_state_next = RUN;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state   <= RUN;
            r_ex_rd   <= '0;
            r_ex_wr   <= 1'b0;
            r_ex_ld   <= 1'b0;
            r_mem_rd  <= '0;
            r_mem_wr  <= 1'b0;
            r_fwd_rs1 <= FORWARD_NONE;
            r_fwd_rs2 <= FORWARD_NONE;
        end else if (!i_freeze) begin
            r_state  <= w_state_next;
            r_mem_rd <= r_ex_rd;
            r_mem_wr <= r_ex_wr;
            if (w_bubble) begin
                r_ex_rd   <= '0;
                r_ex_wr   <= 1'b0;
                r_ex_ld   <= 1'b0;
                r_fwd_rs1 <= FORWARD_NONE;
                r_fwd_rs2 <= FORWARD_NONE;
            end else begin
                r_ex_rd   <= i_id_rd;
                r_ex_wr   <= i_id_valid && i_id_reg_write;
                r_ex_ld   <= i_id_valid && i_id_mem_read;
                r_fwd_rs1 <= w_fwd_rs1;
                r_fwd_rs2 <= w_fwd_rs2;
            end
        end
    end

    // Event counters saturate at all-ones. Events are already gated by freeze.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_stall_evt && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
            if (w_flush_evt && (r_flush_cnt != '1)) begin
                r_flush_cnt <= r_flush_cnt + 1'b1;
            end
        end
    end

    assign o_forward_rs1 = r_fwd_rs1;
    assign o_forward_rs2 = r_fwd_rs2;
    assign o_stall_if    = w_stall;
    assign o_stall_id    = w_stall;
    assign o_ex_bubble   = w_bubble;
    assign o_flush_id    = w_flush;
    assign o_stall_count = r_stall_cnt;
    assign o_flush_count = r_flush_cnt;

endmodule

// File: doc/hazard_control_unit.md
# hazard_control_unit

Pipeline hazard controller for the five-stage RISC-V core. It sits beside decode_stage and execute_stage and tracks the destination registers in flight in EX and MEM. From those it drives the execute stage's forward_rs1/forward_rs2 selects, inserts a one-cycle load-use bubble, and flushes the front end on a taken branch or jump. It also keeps saturating stall and flush event counters for the bench and debug.

## Interface
- REG_ID_W, default 5: register index width.
- CNT_W, default 16: width of each event counter.
- clk, input, 1: core clock, rising edge.
- reset_n, input, 1: asynchronous, active-low reset.
- id_valid, input, 1: the ID stage holds a real instruction.
- id_rs1 / id_rs2, input, REG_ID_W each: source register indices of the ID instruction.
- id_uses_rs1 / id_uses_rs2, input, 1 each: the ID instruction reads that source.
- id_rd, input, REG_ID_W: destination register of the ID instruction.
- id_reg_write, input, 1: the ID instruction writes id_rd.
- id_mem_read, input, 1: the ID instruction is a load.
- ex_pc_src, input, 1: taken branch or jump resolved in EX this cycle.
- freeze, input, 1: global pipeline hold (memory busy).
- forward_rs1 / forward_rs2, output, forward_type: execute-stage operand selects, registered.
- stall_if, output, 1: hold the PC and the IF/ID register.
- stall_id, output, 1: hold the ID instruction.
- ex_bubble, output, 1: load a NOP into ID/EX.
- flush_id, output, 1: clear the IF/ID register.
- stall_count / flush_count, output, CNT_W each: event counters.

## Operation
- **Tracking registers:** ex_rd, ex_wr, ex_ld (instruction now in EX) and mem_rd, mem_wr (instruction now in MEM).
  - On each advance: EX info shifts into MEM, and ID info shifts into EX.
  - A bubble or a flush loads zeros into EX.
- **Hazard match:** a source matches a stage when the source is used, the stage's write flag is set, stage rd equals rs, and rs is not 0. x0 is never forwarded or stalled on.
- **Load-use:** id_valid, and some used source matches EX, and ex_ld is set. The result is stall_if=1, stall_id=1, ex_bubble=1 for exactly one cycle.
- **Forward select**, computed for the ID instruction and registered as it enters EX, with EX match taking priority over MEM match:
  - EX match with ex_ld=0 gives FORWARD_FROM_MEM.
  - MEM match gives FORWARD_FROM_WB. This case covers a load after its one bubble.
  - Otherwise FORWARD_NONE.
- **FSM states:**
  - RUN: normal operation.
  - LOAD_STALL: one bubble cycle. Always returns to RUN.
  - FLUSH: one cycle. Drives flush_id=1 and ex_bubble=1. Returns to RUN.
- **FSM transitions:**
  - RUN goes to FLUSH if ex_pc_src.
  - Otherwise RUN goes to LOAD_STALL if load-use.
- **Priority:** ex_pc_src beats load-use in the same cycle. The stall is dropped because the ID instruction is squashed.
- **freeze=1:**
  - FSM, tracking registers, forward registers and counters all hold.
  - stall_if=1 and stall_id=1.
  - ex_bubble=0 and flush_id=0.
  - A pending ex_pc_src is ignored. EX is held, so the execute stage re-presents it after the freeze ends.
- **Counters:**
  - stall_count increments on each load-use bubble.
  - flush_count increments on each FLUSH entry.
  - Both saturate at all-ones.
- **Reset values:** FSM=RUN, all tracking registers 0, forward_rs1=forward_rs2=FORWARD_NONE, stall/bubble/flush outputs 0, counters 0.
- **Reset mid-stall or mid-flush:** reset returns immediately to RUN with all outputs at reset values.

## Timing
- stall_if, stall_id, ex_bubble and flush_id are combinational. They are decoded from the FSM state, the ID inputs and the tracking registers, and are valid in the same cycle as the hazard.
- forward_rs1 and forward_rs2 are registered. They change on the edge where the ID instruction advances into EX and are stable for the whole EX cycle.
- Load-use costs exactly 1 bubble. A taken branch costs 1 flushed IF/ID slot plus 1 EX bubble.
- No back-to-back FLUSH unless ex_pc_src is asserted again after RUN.

## Structure
- Package common:
  - forward_type values FORWARD_NONE, FORWARD_FROM_MEM, FORWARD_FROM_WB. FORWARD_NONE already exists there.
  - New enum hazard_state_t: RUN, LOAD_STALL, FLUSH.
- One sub-module, hazard_match: purely combinational comparison of rs against one stage (rd, write flag). It is instantiated four times.
- Counters are inline.

## Test plan
- **ALU dependency:** addi x5 is in EX and the ID instruction is add x6,x5,x1. Required: forward_rs1=FORWARD_FROM_MEM in the next cycle, no stall.
- **Distance-2 dependency:** x5 producer is in MEM and ID reads x5 as rs2. Required: forward_rs2=FORWARD_FROM_WB.
- **Load-use:** lw x7 is in EX and ID reads x7.
  - Required: stall_if=stall_id=ex_bubble=1 for 1 cycle, then forward=FORWARD_FROM_WB, stall_count=1.
- **x0 destination:** producer has rd=0 with reg_write=1 and ID reads x0. Required: FORWARD_NONE, no stall.
- **Branch with simultaneous load-use:** ex_pc_src=1 in the same cycle as a load-use.
  - Required: FLUSH with flush_id=1 and ex_bubble=1, stall_if=0, flush_count=1, stall_count unchanged.
- **Freeze, then reset:**
  - freeze=1 for 3 cycles during LOAD_STALL. Required: state and counters hold, and the stall completes after release.
  - reset_n pulsed low mid-FLUSH. Required: all outputs return to 0 and FORWARD_NONE asynchronously.
